// File: rtl/ssc_pkg.sv
// Shared definitions for the single-slope ADC conversion controller.
package ssc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RAMP  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int SETTLE_W = 8;

endpackage

// File: rtl/sync_ff.sv
// N-stage flop synchronizer for a single asynchronous bit, async active-low reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/single_slope_ctrl.sv
// Single-slope ADC conversion controller: discharge, ramp, latch count, valid/ready handoff.
// Optional build macro SSC_OFFSET_CORR_EN removes the synchronizer latency from trip codes.
module single_slope_ctrl
  import ssc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SETTLE      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp,
  input  logic [WIDTH-1:0] cnt_count,
  input  logic             cnt_overflow,
  output logic             cnt_rst,
  output logic             cnt_en,
  output logic             ramp_rst,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_ovf,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                result_ovf_q, result_ovf_d;
  logic                cmp_sync;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_cmp_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (cmp),
    .q_o  (cmp_sync)
  );

`ifdef SSC_OFFSET_CORR_EN
  // The count has advanced SYNC_STAGES times since cmp actually tripped.
  function automatic logic [WIDTH-1:0] trip_code(input logic [WIDTH-1:0] raw);
    if (raw >= WIDTH'(SYNC_STAGES)) begin
      return raw - WIDTH'(SYNC_STAGES);
    end
    return '0;
  endfunction
`else
  function automatic logic [WIDTH-1:0] trip_code(input logic [WIDTH-1:0] raw);
    return raw;
  endfunction
`endif

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    result_d     = result_q;
    result_ovf_d = result_ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_CLEAR;
          settle_d = SETTLE_LOAD;
        end
      end
      ST_CLEAR: begin
        if (settle_q == '0) begin
          state_d = ST_RAMP;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end
      ST_RAMP: begin
        // A set overflow means the count has already wrapped, so it outranks the trip.
        if (cnt_overflow) begin
          result_d     = '1;
          result_ovf_d = 1'b1;
          state_d      = ST_HOLD;
        end else if (cmp_sync) begin
          result_d     = trip_code(cnt_count);
          result_ovf_d = 1'b0;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_q     <= '0;
      result_q     <= '0;
      result_ovf_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      result_q     <= result_d;
      result_ovf_q <= result_ovf_d;
    end
  end

  assign cnt_rst      = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
  assign ramp_rst     = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
  assign cnt_en       = (state_q == ST_RAMP);
  assign result_valid = (state_q == ST_HOLD);
  assign busy         = (state_q != ST_IDLE);
  assign result       = result_q;
  assign result_ovf   = result_ovf_q;

endmodule

// File: tb/tb_single_slope_ctrl.sv
// Bench for single_slope_ctrl with an attached ramp counter and a trip-code reference model.
module tb_single_slope_ctrl;

  localparam int W   = 8;
  localparam int SET = 4;
  localparam int SY  = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cmp = 1'b0;
  logic         result_ready = 1'b0;
  logic [W-1:0] cnt_count;
  logic         cnt_overflow;
  logic         cnt_rst, cnt_en, ramp_rst, busy, result_valid, result_ovf;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  single_slope_ctrl #(
    .WIDTH(W), .SETTLE(SET), .SYNC_STAGES(SY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cmp         (cmp),
    .cnt_count   (cnt_count),
    .cnt_overflow(cnt_overflow),
    .cnt_rst     (cnt_rst),
    .cnt_en      (cnt_en),
    .ramp_rst    (ramp_rst),
    .busy        (busy),
    .result      (result),
    .result_ovf  (result_ovf),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  // Ramp counter: sync reset, increment on enable, sticky overflow once it wraps.
  always_ff @(posedge clk) begin
    if (cnt_rst) begin
      cnt_count    <= '0;
      cnt_overflow <= 1'b0;
    end else if (cnt_en) begin
      cnt_count <= cnt_count + 1'b1;
      if (cnt_count == '1) cnt_overflow <= 1'b1;
    end
  end

  // trip >= 0: cmp rises once the count reads trip; -1: never trips; -2: cmp high before start.
  function automatic void model(input int trip, output logic [W-1:0] code, output logic ovf);
    int lat;
    if (trip == -1) begin
      code = '1; ovf = 1'b1; return;
    end
    lat = (trip == -2) ? 0 : trip + SY;
    if (lat > (1 << W) - 1) begin
      code = '1; ovf = 1'b1; return;
    end
    ovf = 1'b0;
`ifdef SSC_OFFSET_CORR_EN
    lat = (lat >= SY) ? lat - SY : 0;
`endif
    code = W'(lat);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Runs one conversion up to result_valid; leaves the handshake to the caller.
  task automatic do_conv(input int trip, input bit poke, output int clr_cyc);
    int guard;
    result_ready = 1'b0;
    cmp   = (trip == -2);
    start = 1'b1;
    tick();
    start   = 1'b0;
    clr_cyc = 0;
    guard   = 0;
    while (!result_valid && guard < 2000) begin
      if (busy && ramp_rst) clr_cyc++;
      if (trip >= 0 && cnt_en && int'(cnt_count) == trip) cmp = 1'b1;
      start = poke && ((busy && ramp_rst && clr_cyc == 2) || (cnt_en && cnt_count == 8'd10));
      tick();
      guard++;
    end
    start = 1'b0;
    total++;
    if (!result_valid) begin
      bad++;
      $display("FAIL conv_timeout trip=%0d: result_valid=%b required=1", trip, result_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total += 7;
    if (cnt_rst !== 1'b1)      begin bad++; $display("FAIL rst_cnt_rst got=%b exp=1", cnt_rst); end
    if (ramp_rst !== 1'b1)     begin bad++; $display("FAIL rst_ramp_rst got=%b exp=1", ramp_rst); end
    if (cnt_en !== 1'b0)       begin bad++; $display("FAIL rst_cnt_en got=%b exp=0", cnt_en); end
    if (busy !== 1'b0)         begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (result !== '0)         begin bad++; $display("FAIL rst_result got=%0d exp=0", result); end
    if (result_ovf !== 1'b0)   begin bad++; $display("FAIL rst_ovf got=%b exp=0", result_ovf); end
    if (result_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", result_valid); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({cnt_rst, ramp_rst, cnt_en, busy, result_valid} !== 5'b11000) begin
        bad++;
        $display("FAIL idle_hold cyc=%0d got=%b exp=11000", i, {cnt_rst, ramp_rst, cnt_en, busy, result_valid});
      end
    end
  endtask

  task automatic check_conv(input string name, input int trip);
    int clr;
    logic [W-1:0] ec;
    logic eo;
    model(trip, ec, eo);
    do_conv(trip, 1'b0, clr);
    total += 3;
    if (clr !== SET)      begin bad++; $display("FAIL %s_clear_len got=%0d exp=%0d", name, clr, SET); end
    if (result !== ec)    begin bad++; $display("FAIL %s_result trip=%0d got=%0d exp=%0d", name, trip, result, ec); end
    if (result_ovf !== eo) begin bad++; $display("FAIL %s_ovf trip=%0d got=%b exp=%b", name, trip, result_ovf, eo); end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    cmp = 1'b0;
    total += 3;
    if (result_valid !== 1'b0) begin bad++; $display("FAIL %s_valid_drop got=%b exp=0", name, result_valid); end
    if (busy !== 1'b0)         begin bad++; $display("FAIL %s_idle got=%b exp=0", name, busy); end
    if (result !== ec)         begin bad++; $display("FAIL %s_keep got=%0d exp=%0d", name, result, ec); end
  endtask

  task automatic test_normal();
    check_conv("normal", 100);
  endtask

  task automatic test_overflow();
    check_conv("overflow", -1);
    check_conv("simul_ovf", 254);
    check_conv("last_code", 253);
  endtask

  task automatic test_precmp();
    check_conv("precmp", -2);
    check_conv("trip0", 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) check_conv("random", int'($urandom_range(0, 253)));
  endtask

  task automatic test_backpressure();
    int clr;
    int trip;
    logic [W-1:0] ec;
    logic eo;
    trip = int'($urandom_range(20, 200));
    model(trip, ec, eo);
    do_conv(trip, 1'b0, clr);
    for (int i = 0; i < 10; i++) begin
      cmp   = ~cmp;
      start = (i == 3);
      tick();
      total++;
      if ({result_valid, busy, cnt_en, result_ovf, result} !== {1'b1, 1'b1, 1'b0, eo, ec}) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got=%b%b%b%b/%0d exp=110%b/%0d",
                 i, result_valid, busy, cnt_en, result_ovf, result, eo, ec);
      end
    end
    start = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    cmp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({busy, result_valid} !== 2'b00) begin
        bad++; $display("FAIL bp_release cyc=%0d got=%b%b exp=00", i, busy, result_valid);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    int clr;
    int trip;
    logic [W-1:0] ec;
    logic eo;
    trip = int'($urandom_range(30, 150));
    model(trip, ec, eo);
    do_conv(trip, 1'b1, clr);
    total += 2;
    if (clr !== SET)   begin bad++; $display("FAIL ign_clear_len got=%0d exp=%0d", clr, SET); end
    if (result !== ec) begin bad++; $display("FAIL ign_result got=%0d exp=%0d", result, ec); end
    start = 1'b1;
    tick();
    total++;
    if (result_valid !== 1'b1) begin bad++; $display("FAIL ign_hold_start got=%b exp=1", result_valid); end
    result_ready = 1'b1;
    tick();
    start = 1'b0;
    result_ready = 1'b0;
    cmp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL ign_no_second cyc=%0d got=%b exp=0", i, busy); end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    cmp = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(cnt_en && cnt_count == 8'd50) && guard < 500) begin
      tick();
      guard++;
    end
    total++;
    if (guard >= 500) begin bad++; $display("FAIL mid_reach50 got=%0d exp=50", cnt_count); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({cnt_rst, ramp_rst, cnt_en, busy, result_valid, result_ovf, result} !== {5'b11000, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL mid_async got=%b%b%b%b%b%b/%0d exp=110000/0",
               cnt_rst, ramp_rst, cnt_en, busy, result_valid, result_ovf, result);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_conv("after_rst", int'($urandom_range(0, 200)));
  endtask

  initial begin
    test_reset();
    test_normal();
    test_overflow();
    test_precmp();
    test_random();
    test_backpressure();
    test_start_ignored();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
